// File: rtl/sba_apb_bridge.sv
// ---------------------------------------------------------------------------
// sba_apb_bridge
//
// Responder for the debug module's system-bus-access (SBA) master port. Each
// granted SBA transfer becomes exactly one APB3 transfer on a 32-bit lane.
// Only one transfer is in flight at a time.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i .. wdata_i  SBA request side (be_i is ignored, lane = addr_i[2])
//   gnt_o             request accepted (combinational, IDLE only)
//   r_valid_o         one-cycle response pulse, reads and writes alike
//   r_rdata_o, err_o  response payload, held until the next response
//   psel_o .. pwdata_o, prdata_i, pready_i, pslverr_i   APB3 master side
//
// Errors come from pslverr_i or from the ACCESS phase exceeding
// TimeoutCycles cycles; an errored response always returns zero data.
// ---------------------------------------------------------------------------
module sba_apb_bridge #(
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int ApbAddrWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // SBA side
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [AddrWidth-1:0]    addr_i,
    input  logic [DataWidth/8-1:0]  be_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    gnt_o,
    output logic                    r_valid_o,
    output logic [DataWidth-1:0]    r_rdata_o,
    output logic                    err_o,
    // APB side
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ApbAddrWidth-1:0] paddr_o,
    output logic [31:0]             pwdata_o,
    input  logic [31:0]             prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured request
    logic                    we_q;
    logic [ApbAddrWidth-1:0] paddr_q;
    logic [31:0]             pwdata_q;

    // ACCESS-phase wait counter
    logic [CntW-1:0]         cnt_q, cnt_d;

    // Response registers
    logic [DataWidth-1:0]    rdata_q;
    logic                    err_q;

    // Combinational control
    logic                    load_req;
    logic                    load_resp;
    logic                    resp_err_d;
    logic [DataWidth-1:0]    resp_rdata_d;

    // Request decode: word-aligned APB address and 32-bit lane select
    logic [ApbAddrWidth-1:0] paddr_d;
    logic [31:0]             wlane_d;

    assign paddr_d = {addr_i[ApbAddrWidth-1:2], 2'b00};
    assign wlane_d = addr_i[2] ? wdata_i[63:32] : wdata_i[31:0];

    // Byte enables are not used: the APB lane is always a full 32-bit word.
    logic unused_ok;
    assign unused_ok = ^{be_i, addr_i};

    assign r_rdata_o = rdata_q;
    assign err_o     = err_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_o        = 1'b0;
        r_valid_o    = 1'b0;
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        pwrite_o     = 1'b0;
        paddr_o      = '0;
        pwdata_o     = '0;
        load_req     = 1'b0;
        load_resp    = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                // Grant is suppressed while reset is held so that a request
                // overlapping reset is never acknowledged.
                gnt_o = req_i & ~rst_i;
                if (req_i) begin
                    load_req = 1'b1;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                psel_o   = 1'b1;
                pwrite_o = we_q;
                paddr_o  = paddr_q;
                pwdata_o = pwdata_q;
                cnt_d    = '0;
                state_d  = ACCESS;
            end

            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                pwrite_o  = we_q;
                paddr_o   = paddr_q;
                pwdata_o  = pwdata_q;
                // A ready slave wins over a timeout landing in the same cycle.
                if (pready_i) begin
                    load_resp    = 1'b1;
                    resp_err_d   = pslverr_i;
                    resp_rdata_d = (!we_q && !pslverr_i) ? {prdata_i, prdata_i} : '0;
                    state_d      = RESP;
                end else if (cnt_q == CntLast) begin
                    load_resp    = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                r_valid_o = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture, wait counter and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (load_req) begin
                we_q     <= we_i;
                paddr_q  <= paddr_d;
                pwdata_q <= wlane_d;
            end
            if (load_resp) begin
                rdata_q <= resp_rdata_d;
                err_q   <= resp_err_d;
            end
        end
    end

endmodule
